// File: rtl/div_seq_param_if.sv
// div_seq_param_if: operand/result valid-ready bundle for div_seq_param
interface div_seq_param_if #(parameter int DW = 16, parameter int VW = 8);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] A;
    logic [VW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic [DW-1:0] odd;
    logic          div0;
    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, result, odd, div0);
    modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, result, odd, div0);
endinterface

// File: rtl/div_seq_param.sv
// div_seq_param: sequential restoring divider, one quotient bit per clock, valid/ready in and out
// DIV_SIGNED_EN selects two's-complement operands (extra magnitude cycle, sign fix-up on finish)
module div_seq_param #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input logic clk,
    input logic rst,
    div_seq_param_if.slave io
);
    localparam int CW = $clog2(DW + 2);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, nxt;
    logic [DW-1:0] q, res_r, odd_r, res_n, odd_n, rz;
    logic [VW-1:0] bv;
    logic [VW:0] rem, sh, diff;
    logic [CW-1:0] cnt;
    logic z, dz, ge;
`ifdef DIV_SIGNED_EN
    logic sa, sb;
`endif
    assign io.in_ready = state == IDLE;
    assign io.out_valid = state == DONE;
    assign io.result = res_r;
    assign io.odd = odd_r;
    assign io.div0 = dz;
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (io.in_valid ? CALC : IDLE) :
              state == CALC ? (cnt == '0 ? DONE : CALC) :
              (io.out_ready ? IDLE : DONE);
    end
    // cnt == 0 in CALC is the registering cycle; B == 0 lands there directly
    always_comb begin
        sh = {rem[VW-1:0], q[DW-1]};
        diff = sh - {1'b0, bv};
        ge = sh >= {1'b0, bv};
        rz = DW'(rem);
`ifdef DIV_SIGNED_EN
        res_n = z ? '0 : (sa ^ sb) ? -q : q;
        odd_n = z ? q : sa ? -rz : rz;
`else
        res_n = z ? '0 : q;
        odd_n = z ? q : rz;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q <= '0;
            bv <= '0;
            rem <= '0;
            cnt <= '0;
            z <= 1'b0;
            dz <= 1'b0;
            res_r <= '0;
            odd_r <= '0;
`ifdef DIV_SIGNED_EN
            sa <= 1'b0;
            sb <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == IDLE && io.in_valid) begin
                q <= io.A;
                bv <= io.B;
                rem <= '0;
                z <= io.B == '0;
`ifdef DIV_SIGNED_EN
                sa <= io.A[DW-1];
                sb <= io.B[VW-1];
                cnt <= io.B == '0 ? '0 : CW'(DW + 1);
`else
                cnt <= io.B == '0 ? '0 : CW'(DW);
`endif
            end else if (state == CALC) begin
                if (cnt == '0) begin
                    res_r <= res_n;
                    odd_r <= odd_n;
                    dz <= z;
`ifdef DIV_SIGNED_EN
                end else if (cnt == CW'(DW + 1)) begin
                    q <= sa ? -q : q;
                    bv <= sb ? -bv : bv;
                    cnt <= cnt - 1'b1;
`endif
                end else begin
                    rem <= ge ? diff : sh;
                    q <= {q[DW-2:0], ge};
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: directed vectors for div_seq_param (DW=16, VW=8)
module tb_div_seq_param;
    localparam int DW = 16;
    localparam int VW = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = DW + 2;
`else
    localparam int LAT = DW + 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errs = 0;
    div_seq_param_if #(.DW(DW), .VW(VW)) io ();
    div_seq_param #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic start(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        chk("in_ready_pre", {31'd0, io.in_ready}, 32'd1);
        io.A = a;
        io.B = b;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.A = '0;
        io.B = '0;
    endtask
    task automatic wait_done(input string tag, input int lat);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!io.out_valid && n < 100);
        chk({tag, "_lat"}, n, lat);
    endtask
    task automatic run(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b, input int lat,
                       input logic [DW-1:0] er, input logic [DW-1:0] eo, input logic ez);
        start(a, b);
        wait_done(tag, lat);
        chk({tag, "_res"}, 32'(io.result), 32'(er));
        chk({tag, "_odd"}, 32'(io.odd), 32'(eo));
        chk({tag, "_div0"}, {31'd0, io.div0}, {31'd0, ez});
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, {31'd0, io.out_valid}, 32'd0);
    endtask
    initial begin
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        io.A = '0;
        io.B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("rst_res", 32'(io.result), 32'd0);
        chk("rst_odd", 32'(io.odd), 32'd0);
        chk("rst_div0", {31'd0, io.div0}, 32'd0);
        rst = 1'b0;
        run("d1000_7", 16'd1000, 8'd7, LAT, 16'd142, 16'd6, 1'b0);
        run("dffff_1", 16'hFFFF, 8'h01, LAT, 16'hFFFF, 16'd0, 1'b0);
        run("d00ff_ff", 16'h00FF, 8'hFF, LAT, 16'd1, 16'd0, 1'b0);
        run("dzero", 16'h1234, 8'h00, 1, 16'd0, 16'h1234, 1'b1);
        // backpressure with a stray in_valid that must be ignored
        io.out_ready = 1'b0;
        start(16'd500, 8'd9);
        wait_done("bp", LAT);
        io.in_valid = 1'b1;
        io.A = 16'd7;
        io.B = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, io.out_valid}, 32'd1);
            chk("bp_res", 32'(io.result), 32'd55);
            chk("bp_odd", 32'(io.odd), 32'd5);
            chk("bp_in_ready", {31'd0, io.in_ready}, 32'd0);
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drop", {31'd0, io.out_valid}, 32'd0);
        chk("bp_idle", {31'd0, io.in_ready}, 32'd1);
        chk("bp_hold_res", 32'(io.result), 32'd55);
        run("d81_9", 16'd81, 8'd9, LAT, 16'd9, 16'd0, 1'b0);
        // reset during the fifth CALC cycle
        start(16'd200, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_valid", {31'd0, io.out_valid}, 32'd0);
        chk("mrst_res", 32'(io.result), 32'd0);
        chk("mrst_odd", 32'(io.odd), 32'd0);
        chk("mrst_in_ready", {31'd0, io.in_ready}, 32'd1);
        rst = 1'b0;
        run("d100_10", 16'd100, 8'd10, LAT, 16'd10, 16'd0, 1'b0);
`ifdef DIV_SIGNED_EN
        run("sneg1000_7", 16'hFC18, 8'd7, LAT, 16'hFF72, 16'hFFFA, 1'b0);
        run("sovf", 16'h8000, 8'hFF, LAT, 16'h8000, 16'd0, 1'b0);
        run("s1000_neg7", 16'd1000, 8'hF9, LAT, 16'hFF72, 16'd6, 1'b0);
`else
        run("d8000_ff", 16'h8000, 8'hFF, LAT, 16'd128, 16'd128, 1'b0);
        run("d7_200", 16'd7, 8'd200, LAT, 16'd0, 16'd7, 1'b0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
